// File: rtl/ccgrcg_bist_ctrl.sv
// ccgrcg_bist_ctrl: exhaustive-pattern BIST controller for a CCGRCG
// benchmark netlist, with MISR response compaction and golden compare.
module ccgrcg_bist_ctrl #(
    parameter int               N_IN       = 5,
    parameter int               N_OUT      = 11,
    parameter logic [N_OUT-1:0] MISR_POLY  = 'h005,
    parameter logic [N_OUT-1:0] MISR_SEED  = '0,
    parameter logic [N_OUT-1:0] GOLDEN_SIG = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] f,
    output logic [N_IN-1:0]  x,
    output logic             busy,
    output logic             done,
    output logic [N_OUT-1:0] signature,
    output logic             pass
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N_IN-1:0] X_LAST = '1;
    localparam logic [N_IN-1:0] X_ONE  = 1;

    state_t           state_q;
    state_t           state_d;
    logic [N_IN-1:0]  x_q;
    logic [N_IN-1:0]  x_d;
    logic [N_OUT-1:0] sig_q;
    logic [N_OUT-1:0] sig_d;
    logic [N_OUT-1:0] sig_step;

    // MISR step: shift, fold the MSB back through the taps, absorb f
    always_comb begin
        sig_step = {sig_q[N_OUT-2:0], 1'b0} ^ f;
        if (sig_q[N_OUT-1]) begin
            sig_step = sig_step ^ MISR_POLY;
        end
    end

    // Next-state, stimulus and signature update; abort overrides all
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        sig_d   = sig_q;
        if (abort) begin
            state_d = IDLE;
            x_d     = '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = RUN;
                        x_d     = '0;
                        sig_d   = MISR_SEED;
                    end
                end
                RUN: begin
                    sig_d = sig_step;
                    if (x_q == X_LAST) begin
                        state_d = DONE;
                    end else begin
                        x_d = x_q + X_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    x_d     = '0;
                end
            endcase
        end
    end

    // State, stimulus counter and signature registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            sig_q   <= sig_d;
        end
    end

    assign x         = x_q;
    assign signature = sig_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pass      = done && (sig_q == GOLDEN_SIG);

endmodule
